// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder, the control unit and the Cause logic.
package mem_pkg;

   localparam int unsigned MEM_DATA_W      = 16;
   localparam int unsigned MEM_ADDR_W      = 16;
   localparam int unsigned MEM_DEPTH_LOG2  = 10;
   localparam int unsigned MEM_WAIT_STATES = 1;
   localparam int unsigned MEM_WAIT_MAX    = 7;
   localparam logic [15:0] MEM_IO_OUT_ADDR = 16'hFFFE;
   localparam logic [15:0] MEM_IO_IN_ADDR  = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } mem_state_e;

   // The wait counter is only 3 bits, so larger requests saturate at 7.
   function automatic logic [2:0] clamp_wait(input int unsigned ws);
      if (ws > MEM_WAIT_MAX) begin
         return 3'd7;
      end else begin
         return ws[2:0];
      end
   endfunction

endpackage

// File: rtl/mem_responder_ram_sp.sv
// Single-port synchronous RAM with write enable and registered (read-first) output.
module ram_sp
   import mem_pkg::*;
#(
   parameter int unsigned DATA_W = MEM_DATA_W,
   parameter int unsigned ADDR_W = MEM_DEPTH_LOG2
) (
   input  logic              CLK,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] r_mem [0:DEPTH-1];
   logic [DATA_W-1:0] r_rdata;

   // Storage array and output register; contents are deliberately not reset.
   always_ff @(posedge CLK) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
      r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: wait-state sequencer, RAM/IO address decode and
// completion/error reporting for the multicycle datapath.
module mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned       DATA_W      = MEM_DATA_W,
   parameter int unsigned       ADDR_W      = MEM_ADDR_W,
   parameter int unsigned       DEPTH_LOG2  = MEM_DEPTH_LOG2,
   parameter int unsigned       WAIT_STATES = MEM_WAIT_STATES,
   parameter logic [ADDR_W-1:0] IO_OUT_ADDR = MEM_IO_OUT_ADDR,
   parameter logic [ADDR_W-1:0] IO_IN_ADDR  = MEM_IO_IN_ADDR
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [DATA_W-1:0] WriteData,
   input  logic [DATA_W-1:0] IoIn,
   output logic [DATA_W-1:0] ReadData,
   output logic              MemReady,
   output logic              MemBusy,
   output logic              AddrErr,
   output logic              Overrun,
   output logic [DATA_W-1:0] IoOut
);

   localparam logic [2:0]  WS_EFF    = clamp_wait(WAIT_STATES);
   localparam int unsigned RAM_TOP_W = ADDR_W - DEPTH_LOG2;

   mem_state_e          r_state;
   mem_state_e          w_next_state;
   logic [2:0]          r_wait_cnt;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_is_read;
   logic                r_is_write;
   logic                r_err;
   logic [DATA_W-1:0]   r_read_data;
   logic [DATA_W-1:0]   r_io_out;
   logic                r_mem_ready;
   logic                r_mem_busy;
   logic                r_addr_err;
   logic                r_overrun;

   logic                w_req_rd;
   logic                w_req_wr;
   logic                w_conflict;
   logic                w_accept;
   logic                w_acc_err;
   logic                w_next_err;
   logic                w_sel_ram;
   logic                w_sel_out;
   logic                w_sel_in;
   logic                w_ram_we;
   logic [DEPTH_LOG2-1:0] w_ram_addr;
   logic [DATA_W-1:0]   w_ram_rdata;
   logic [DATA_W-1:0]   w_resp_rdata;

   // Fault classification: conflicting strobes, stores to read-only/unmapped
   // space, loads from unmapped space.
   function automatic logic f_access_err(input logic [ADDR_W-1:0] a,
                                         input logic rd, input logic wr);
      logic in_ram;
      logic is_out;
      logic is_in;
      in_ram = (a[ADDR_W-1:DEPTH_LOG2] == {RAM_TOP_W{1'b0}});
      is_out = (a == IO_OUT_ADDR);
      is_in  = (a == IO_IN_ADDR);
      return (rd & wr)
           | (wr & ~rd & ~(in_ram | is_out))
           | (rd & ~wr & ~(in_ram | is_out | is_in));
   endfunction

   assign w_req_rd   = MemRead & ~MemWrite;
   assign w_req_wr   = MemWrite & ~MemRead;
   assign w_conflict = MemRead & MemWrite;
   assign w_accept   = (r_state == ST_IDLE) & (MemRead | MemWrite);
   assign w_acc_err  = f_access_err(Addr, MemRead, MemWrite);
   assign w_next_err = (r_state == ST_IDLE) ? w_acc_err : r_err;

   assign w_sel_ram  = (r_addr[ADDR_W-1:DEPTH_LOG2] == {RAM_TOP_W{1'b0}});
   assign w_sel_out  = (r_addr == IO_OUT_ADDR);
   assign w_sel_in   = (r_addr == IO_IN_ADDR);
   assign w_ram_we   = (r_state == ST_RESP) & r_is_write & w_sel_ram;

   // State register.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; a conflicting request skips the wait states.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_conflict) begin
               w_next_state = ST_RESP;
            end else if (w_req_rd | w_req_wr) begin
               w_next_state = (WS_EFF == 3'd0) ? ST_RESP : ST_WAIT;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (r_wait_cnt == 3'd0) begin
               w_next_state = ST_RESP;
            end else begin
               w_next_state = ST_WAIT;
            end
         end
         ST_RESP: w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // While idle the RAM reads the live address so the word is ready by RESP.
   always_comb begin
      if (r_state == ST_IDLE) begin
         w_ram_addr = Addr[DEPTH_LOG2-1:0];
      end else begin
         w_ram_addr = r_addr[DEPTH_LOG2-1:0];
      end
   end

   // Load-data source selection on the latched address.
   always_comb begin
      if (w_sel_ram) begin
         w_resp_rdata = w_ram_rdata;
      end else if (w_sel_out) begin
         w_resp_rdata = r_io_out;
      end else if (w_sel_in) begin
         w_resp_rdata = IoIn;
      end else begin
         w_resp_rdata = {DATA_W{1'b0}};
      end
   end

   // Request latch, wait counter, I/O registers and registered status outputs.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_wait_cnt  <= 3'd0;
         r_addr      <= {ADDR_W{1'b0}};
         r_wdata     <= {DATA_W{1'b0}};
         r_is_read   <= 1'b0;
         r_is_write  <= 1'b0;
         r_err       <= 1'b0;
         r_read_data <= {DATA_W{1'b0}};
         r_io_out    <= {DATA_W{1'b0}};
         r_mem_ready <= 1'b0;
         r_mem_busy  <= 1'b0;
         r_addr_err  <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_mem_ready <= (w_next_state == ST_RESP);
         r_mem_busy  <= (w_next_state != ST_IDLE);
         r_addr_err  <= (w_next_state == ST_RESP) & w_next_err;

         if (w_accept) begin
            r_addr     <= Addr;
            r_wdata    <= WriteData;
            r_is_read  <= w_req_rd;
            r_is_write <= w_req_wr;
            r_err      <= w_acc_err;
            r_wait_cnt <= WS_EFF - 3'd1;
         end else if (r_state == ST_WAIT) begin
            r_wait_cnt <= r_wait_cnt - 3'd1;
         end

         if ((r_state != ST_IDLE) & (MemRead | MemWrite)) begin
            r_overrun <= 1'b1;
         end

         if ((r_state == ST_RESP) & r_is_read) begin
            r_read_data <= w_resp_rdata;
         end

         if ((r_state == ST_RESP) & r_is_write & w_sel_out) begin
            r_io_out <= r_wdata;
         end
      end
   end

   ram_sp #(
      .DATA_W (DATA_W),
      .ADDR_W (DEPTH_LOG2)
   ) u_ram (
      .CLK     (CLK),
      .i_we    (w_ram_we),
      .i_addr  (w_ram_addr),
      .i_wdata (r_wdata),
      .o_rdata (w_ram_rdata)
   );

   assign ReadData = r_read_data;
   assign MemReady = r_mem_ready;
   assign MemBusy  = r_mem_busy;
   assign AddrErr  = r_addr_err;
   assign Overrun  = r_overrun;
   assign IoOut    = r_io_out;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a transaction-level memory model.
module tb_mem_responder;

   localparam int WS = 1;

   logic        CLK;
   logic        Reset;
   logic        MemRead;
   logic        MemWrite;
   logic [15:0] Addr;
   logic [15:0] WriteData;
   logic [15:0] IoIn;
   logic [15:0] ReadData;
   logic        MemReady;
   logic        MemBusy;
   logic        AddrErr;
   logic        Overrun;
   logic [15:0] IoOut;

   int n_checks;
   int n_fails;

   // reference model state
   logic [15:0] m_mem [0:1023];
   logic [15:0] m_io_out;
   logic [15:0] m_read_data;

   mem_responder #(
      .WAIT_STATES (WS)
   ) dut (
      .CLK       (CLK),
      .Reset     (Reset),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .Addr      (Addr),
      .WriteData (WriteData),
      .IoIn      (IoIn),
      .ReadData  (ReadData),
      .MemReady  (MemReady),
      .MemBusy   (MemBusy),
      .AddrErr   (AddrErr),
      .Overrun   (Overrun),
      .IoOut     (IoOut)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // One complete access, driven from a negedge; strobes drop right after acceptance.
   task automatic access(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [15:0] wd, input logic [15:0] io_in);
      int          k;
      int          exp_lat;
      logic        exp_err;
      logic [15:0] exp_rd;
      logic        in_ram;
      MemRead   = rd;
      MemWrite  = wr;
      Addr      = a;
      WriteData = wd;
      IoIn      = io_in;
      @(posedge CLK);
      @(negedge CLK);
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      chk("busy_after_accept", 32'(MemBusy), 32'd1);
      k = 1;
      while (!MemReady && k < 20) begin
         @(negedge CLK);
         k++;
      end

      in_ram  = (a < 16'h0400);
      exp_err = 1'b0;
      exp_rd  = m_read_data;
      exp_lat = (rd && wr) ? 1 : WS + 1;
      if (rd && wr) begin
         exp_err = 1'b1;
      end else if (rd) begin
         if (in_ram)                exp_rd = m_mem[a[9:0]];
         else if (a == 16'hFFFE)    exp_rd = m_io_out;
         else if (a == 16'hFFFF)    exp_rd = io_in;
         else begin exp_rd = 16'h0000; exp_err = 1'b1; end
      end else begin
         if (in_ram)                m_mem[a[9:0]] = wd;
         else if (a == 16'hFFFE)    m_io_out = wd;
         else                       exp_err = 1'b1;
      end
      m_read_data = exp_rd;

      chk("latency", 32'(k), 32'(exp_lat));
      chk("addr_err_at_ready", 32'(AddrErr), 32'(exp_err));
      chk("busy_at_ready", 32'(MemBusy), 32'd1);
      @(negedge CLK);
      chk("read_data", 32'(ReadData), 32'(exp_rd));
      chk("ready_pulse_end", 32'(MemReady), 32'd0);
      chk("addr_err_pulse_end", 32'(AddrErr), 32'd0);
      chk("busy_end", 32'(MemBusy), 32'd0);
      chk("io_out", 32'(IoOut), 32'(m_io_out));
   endtask

   initial begin
      logic [15:0] a;
      logic [15:0] pool_a;
      int          kind;
      n_checks    = 0;
      n_fails     = 0;
      m_io_out    = 16'h0000;
      m_read_data = 16'h0000;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      Addr        = 16'h0000;
      WriteData   = 16'h0000;
      IoIn        = 16'h0000;
      Reset       = 1'b1;
      repeat (2) @(negedge CLK);
      chk("rst_read_data", 32'(ReadData), 32'd0);
      chk("rst_ready", 32'(MemReady), 32'd0);
      chk("rst_busy", 32'(MemBusy), 32'd0);
      chk("rst_addr_err", 32'(AddrErr), 32'd0);
      chk("rst_overrun", 32'(Overrun), 32'd0);
      chk("rst_io_out", 32'(IoOut), 32'd0);
      Reset = 1'b0;
      @(negedge CLK);

      // Directed: RAM write/read, IO port, boundary and error cases.
      access(1'b0, 1'b1, 16'd5, 16'h1234, 16'h0000);
      access(1'b1, 1'b0, 16'd5, 16'h0000, 16'h0000);
      access(1'b0, 1'b1, 16'd0, 16'hA5A5, 16'h0000);
      access(1'b0, 1'b1, 16'hFFFE, 16'hBEEF, 16'h00AA);
      access(1'b1, 1'b0, 16'hFFFE, 16'h0000, 16'h00AA);
      access(1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h00AA);
      access(1'b1, 1'b0, 16'h0400, 16'h0000, 16'h00AA);
      access(1'b0, 1'b1, 16'hFFFF, 16'h7777, 16'h00AA);
      access(1'b1, 1'b0, 16'd0, 16'h0000, 16'h00AA);
      access(1'b1, 1'b1, 16'd5, 16'hDEAD, 16'h00AA);
      access(1'b1, 1'b0, 16'd5, 16'h0000, 16'h00AA);
      access(1'b0, 1'b1, 16'h03FF, 16'h3FF0, 16'h0000);
      access(1'b1, 1'b0, 16'h03FF, 16'h0000, 16'h0000);

      // Seed a small RAM pool so every random load has a known value.
      for (int i = 0; i < 32; i++) begin
         pool_a = (i < 16) ? 16'(i) : 16'(1008 + i - 16);
         access(1'b0, 1'b1, pool_a, 16'($urandom), 16'h0000);
      end

      for (int n = 0; n < 80; n++) begin
         kind = int'($urandom_range(0, 9));
         pool_a = 16'($urandom_range(0, 31));
         if (pool_a >= 16'd16) pool_a = pool_a + 16'd992;
         case (kind)
            5:       a = 16'hFFFE;
            6:       a = 16'hFFFF;
            7:       a = 16'($urandom_range(16'h0400, 16'hFFFD));
            default: a = pool_a;
         endcase
         if (kind == 8) begin
            access(1'b1, 1'b1, a, 16'($urandom), 16'($urandom));
         end else if ($urandom_range(0, 1) == 0) begin
            access(1'b1, 1'b0, a, 16'($urandom), 16'($urandom));
         end else begin
            access(1'b0, 1'b1, a, 16'($urandom), 16'($urandom));
         end
      end
      chk("no_overrun_yet", 32'(Overrun), 32'd0);

      // Overrun: store request raised during the WAIT of a load.
      access(1'b0, 1'b1, 16'd6, 16'h0606, 16'h0000);
      MemRead = 1'b1;
      Addr    = 16'd5;
      @(posedge CLK);
      @(negedge CLK);
      MemRead   = 1'b0;
      MemWrite  = 1'b1;
      Addr      = 16'd6;
      WriteData = 16'hFACE;
      @(negedge CLK);
      MemWrite = 1'b0;
      chk("ovr_first_ready", 32'(MemReady), 32'd1);
      chk("ovr_set", 32'(Overrun), 32'd1);
      @(negedge CLK);
      m_read_data = m_mem[5];
      chk("ovr_first_data", 32'(ReadData), 32'(m_mem[5]));
      access(1'b1, 1'b0, 16'd6, 16'h0000, 16'h0000);
      chk("ovr_sticky", 32'(Overrun), 32'd1);

      // Reset during WAIT aborts the store.
      access(1'b0, 1'b1, 16'd7, 16'h0001, 16'h0000);
      MemWrite  = 1'b1;
      Addr      = 16'd7;
      WriteData = 16'h5555;
      @(posedge CLK);
      @(negedge CLK);
      MemWrite = 1'b0;
      chk("abort_busy_before", 32'(MemBusy), 32'd1);
      Reset = 1'b1;
      #1;
      chk("abort_busy", 32'(MemBusy), 32'd0);
      chk("abort_ready", 32'(MemReady), 32'd0);
      @(negedge CLK);
      Reset = 1'b0;
      m_io_out    = 16'h0000;
      m_read_data = 16'h0000;
      chk("abort_overrun_clr", 32'(Overrun), 32'd0);
      chk("abort_read_data", 32'(ReadData), 32'd0);
      @(negedge CLK);
      access(1'b1, 1'b0, 16'd7, 16'h0000, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle datapath. It services the MemRead/MemWrite requests issued by the control unit during Fetch, LW1 and SW.
- Contains a word-addressed RAM, a wait-state sequencer and two memory-mapped I/O registers.
- Reports completion via MemReady and bad accesses via AddrErr, which feed the EXCEPTION/Cause logic.

Parameters:
- DATA_W, 16, data word width
- ADDR_W, 16, address width (word addresses)
- DEPTH_LOG2, 10, RAM holds 2^DEPTH_LOG2 words at addresses 0..2^DEPTH_LOG2-1
- WAIT_STATES, 1, extra cycles between request acceptance and response (0..7)
- IO_OUT_ADDR, 16'hFFFE, address of the writable output port register
- IO_IN_ADDR, 16'hFFFF, address of the read-only input port

Ports:
- CLK  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high
- MemRead  in  1  read request (level, sampled on CLK)
- MemWrite  in  1  write request (level, sampled on CLK)
- Addr  in  ADDR_W  word address (already muxed by IorD)
- WriteData  in  DATA_W  store data
- IoIn  in  DATA_W  external input port value
- ReadData  out  DATA_W  read result; holds until the next read completes
- MemReady  out  1  one-cycle pulse when the accepted access completes
- MemBusy  out  1  high from acceptance until the MemReady cycle, inclusive
- AddrErr  out  1  one-cycle pulse in the completion cycle of a faulting access
- Overrun  out  1  sticky; set by a request while busy, cleared only by Reset
- IoOut  out  DATA_W  output port register

Behaviour:
- Reset (async) values: state IDLE, ReadData=0, MemReady=0, MemBusy=0, AddrErr=0, Overrun=0, IoOut=0, wait counter=0. RAM contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - On a CLK edge with exactly one of MemRead/MemWrite high, latch Addr, WriteData and direction.
  - Then go to WAIT if WAIT_STATES>0 (counter loaded with WAIT_STATES-1), else go to RESP.
- WAIT: decrement the counter each cycle. At 0, go to RESP.
- RESP (one cycle), using the latched request:
  - MemReady=1, MemBusy=1.
  - Read: ReadData updates at the end of this cycle and is valid from the next cycle.
  - Write: RAM or IoOut updates at the end of this cycle.
  - Always returns to IDLE. Back-to-back requests are therefore accepted at best every WAIT_STATES+2 cycles.
- Total latency: acceptance edge to MemReady = WAIT_STATES+1 cycles. With default 1: LW1 accept, LWSTALL, LW2 data valid.
- Address decode on the latched address:
  - Addr < 2^DEPTH_LOG2: RAM.
  - Addr == IO_OUT_ADDR: read returns IoOut; write updates IoOut.
  - Addr == IO_IN_ADDR: read returns IoIn sampled in RESP; write is dropped with AddrErr=1.
  - Any other address: read returns 0; write is dropped; AddrErr=1 in RESP.
- Both MemRead and MemWrite high in IDLE:
  - No access; go directly to RESP-error.
  - MemReady=1, AddrErr=1, ReadData unchanged.
- Request while MemBusy (WAIT/RESP): ignored, Overrun set. Requests seen in the RESP cycle also count as overrun.
- Level request held past MemReady:
  - Re-accepted in IDLE as a new access.
  - The control unit deasserts in the next state, so a held level is treated as a new request by design.
- Reset mid-operation: the access is aborted, no RAM write occurs, and the FSM returns to IDLE immediately.
- WAIT_STATES values above 7 are clamped to 7. The counter is 3 bits wide.

Decomposition:
- Package mem_pkg:
  - state encodings IDLE/WAIT/RESP
  - IO_OUT_ADDR and IO_IN_ADDR defaults
  - DATA_W and ADDR_W
  - shared with the control unit and the Cause logic
- Sub-module ram_sp (single-port synchronous RAM, DEPTH_LOG2 x DATA_W, write enable, registered read) is natural. The FSM, decode and I/O registers stay in mem_responder.

Test Plan:
- Reset, then write 16'h1234 to address 5, then read address 5 (WAIT_STATES=1) -> MemReady pulses 2 cycles after each acceptance; ReadData=16'h1234 the cycle after read MemReady.
- Write 16'hBEEF to 16'hFFFE, then read 16'hFFFE with IoIn=16'h00AA; then read 16'hFFFF -> IoOut=16'hBEEF and first read=16'hBEEF; second read=16'h00AA; AddrErr stays 0.
- Read 16'h0400 (just past RAM) and write 16'hFFFF -> each gives one AddrErr pulse coincident with MemReady; read returns 0; RAM address 0 unchanged.
- MemRead and MemWrite both high in IDLE -> MemReady and AddrErr pulse 1 cycle later; ReadData unchanged; no writes.
- Issue read, then assert MemWrite during WAIT -> Overrun=1 and stays 1; the second request is not performed; the first completes normally.
- Assert Reset during WAIT of a write of 16'h5555 to address 7 (previously 16'h0001) -> MemBusy=0 immediately; a later read of address 7 returns 16'h0001.
